// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module  : ram_arb_pkg
// Purpose : Shared widths, FSM state encoding and port ids for ram_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    localparam int ADDR_W_DFLT = 7;
    localparam int DATA_W_DFLT = 32;

    localparam logic P_DATA  = 1'b0;
    localparam logic P_FETCH = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_arb_if.sv
// ============================================================================
// Module  : ram_arb_if
// Purpose : Requester handshakes plus RAM pins for the two-port RAM arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface ram_arb_if import ram_arb_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) ();

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              ram_en;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    // master = requesters plus the RAM model; slave = the arbiter
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        input  ack0, ack1, rdata0, rdata1, ram_en, ram_rw, ram_addr, ram_din
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        output ack0, ack1, rdata0, rdata1, ram_en, ram_rw, ram_addr, ram_din
    );

endinterface

`default_nettype wire

// File: rtl/ram_arb_pick.sv
// ============================================================================
// Module  : ram_arb_pick
// Purpose : Winner select between data (0) and fetch (1) requesters.
//           RAM_ARB_RR_EN selects round-robin with a last-grant pointer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_arb_pick import ram_arb_pkg::*; (
`ifdef RAM_ARB_RR_EN
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic take,
`endif
    input  wire logic req0,
    input  wire logic req1,
    output logic      grant
);

`ifdef RAM_ARB_RR_EN
    logic r_last;

    // Reset to the fetch port so the first tie goes to the data port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= P_FETCH;
        end else if (take) begin
            r_last <= grant;
        end
    end

    always_comb begin
        grant = P_DATA;
        if (req0 && req1) begin
            grant = ~r_last;
        end else if (req1) begin
            grant = P_FETCH;
        end
    end
`else
    always_comb begin
        grant = P_DATA;
        if (!req0 && req1) begin
            grant = P_FETCH;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module  : ram_arbiter
// Purpose : Shares a single-port 128x32 RAM between data and fetch ports,
//           one access per three cycles. Option macro: RAM_ARB_RR_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_arbiter import ram_arb_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  wire logic clk,
    input  wire logic reset,
    ram_arb_if.slave  bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_id;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_any;
    logic              w_grant;
    logic              w_en;
    logic              w_rw;
    logic              w_ack0;
    logic              w_ack1;

    assign w_any = bus.req0 | bus.req1;

`ifdef RAM_ARB_RR_EN
    logic w_take;
    assign w_take = (r_state == IDLE) && w_any;

    ram_arb_pick u_pick (
        .clk   (clk),
        .reset (reset),
        .take  (w_take),
        .req0  (bus.req0),
        .req1  (bus.req1),
        .grant (w_grant)
    );
`else
    ram_arb_pick u_pick (
        .req0  (bus.req0),
        .req1  (bus.req1),
        .grant (w_grant)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_en        = 1'b0;
        w_rw        = 1'b1;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_en        = 1'b1;
                w_rw        = ~r_we;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_ack0      = (r_id == P_DATA);
                w_ack1      = (r_id == P_FETCH);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Fields only change on grant, so the RAM address/data pins hold between accesses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id    <= P_DATA;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == IDLE) && w_any) begin
            r_id    <= w_grant;
            r_we    <= (w_grant == P_FETCH) ? bus.we1    : bus.we0;
            r_addr  <= (w_grant == P_FETCH) ? bus.addr1  : bus.addr0;
            r_wdata <= (w_grant == P_FETCH) ? bus.wdata1 : bus.wdata0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if ((r_state == ACCESS) && !r_we) begin
            if (r_id == P_FETCH) begin
                r_rdata1 <= bus.ram_dout;
            end else begin
                r_rdata0 <= bus.ram_dout;
            end
        end
    end

    assign bus.ram_en   = w_en;
    assign bus.ram_rw   = w_rw;
    assign bus.ram_addr = r_addr;
    assign bus.ram_din  = r_wdata;
    assign bus.ack0     = w_ack0;
    assign bus.ack1     = w_ack1;
    assign bus.rdata0   = r_rdata0;
    assign bus.rdata1   = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module  : tb_ram_arbiter
// Purpose : Directed bench for ram_arbiter with a cycle-timestamp reference
//           model and a behavioural 128x32 RAM. Honours RAM_ARB_RR_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic clk;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;

    ram_arb_if bus ();

    ram_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ram128x32: synchronous write, combinational read
    logic [31:0] mem [128];
    always @(posedge clk) begin
        if (bus.ram_en && !bus.ram_rw) mem[bus.ram_addr] <= bus.ram_din;
    end
    assign bus.ram_dout = mem[bus.ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant at edge g means RAM enabled in the window after
    // edge g, ack in the window after g+1, next grant no earlier than edge g+3.
    int          k   = 0;
    int          g   = -10;
    logic        m_id, m_we, m_last;
    logic [6:0]  m_a;
    logic [31:0] m_d;
    logic [31:0] m_rd0, m_rd1;
    logic [31:0] mmem [128];

    always @(posedge clk) begin
        logic r0, r1, win;
        r0 = bus.req0;
        r1 = bus.req1;
        k++;
        if (k == g + 1) begin
            if (m_we) mmem[m_a] = m_d;
            else if (!reset) begin
                if (m_id) m_rd1 = mmem[m_a];
                else      m_rd0 = mmem[m_a];
            end
        end
        if (reset) begin
            g = -10; m_id = 0; m_we = 0; m_a = 0; m_d = 0;
            m_rd0 = 0; m_rd1 = 0; m_last = 1;
        end else if (k >= g + 3 && (r0 || r1)) begin
`ifdef RAM_ARB_RR_EN
            win = (r0 && r1) ? ~m_last : r1;
`else
            win = !r0;
`endif
            g      = k;
            m_id   = win;
            m_we   = win ? bus.we1    : bus.we0;
            m_a    = win ? bus.addr1  : bus.addr0;
            m_d    = win ? bus.wdata1 : bus.wdata0;
            m_last = win;
        end
        #2;
        chk("ram_en",   {31'd0, bus.ram_en},   {31'd0, k == g});
        chk("ram_rw",   {31'd0, bus.ram_rw},   {31'd0, (k == g) ? ~m_we : 1'b1});
        chk("ram_addr", {25'd0, bus.ram_addr}, {25'd0, m_a});
        chk("ram_din",  bus.ram_din,           m_d);
        chk("ack0",     {31'd0, bus.ack0},     {31'd0, (k == g + 1) && !m_id});
        chk("ack1",     {31'd0, bus.ack1},     {31'd0, (k == g + 1) && m_id});
        chk("rdata0",   bus.rdata0,            m_rd0);
        chk("rdata1",   bus.rdata1,            m_rd1);
    end

    // One access on one port; lat counts edges from request to the ack window
    task automatic do_access(input logic port, input logic we, input logic [6:0] a,
                             input logic [31:0] d, input bit drop_early,
                             output int lat, output int en_cnt, output logic rw,
                             output logic [31:0] rd);
        bit got = 0;
        @(negedge clk);
        if (port) begin bus.req1 = 1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; end
        else      begin bus.req0 = 1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; end
        lat = 0; en_cnt = 0; rw = 1'bx; rd = 0;
        for (int i = 1; i <= 6 && !got; i++) begin
            @(posedge clk); #2;
            if (bus.ram_en) begin en_cnt++; rw = bus.ram_rw; end
            if (port ? bus.ack1 : bus.ack0) begin
                got = 1; lat = i; rd = port ? bus.rdata1 : bus.rdata0;
            end
            @(negedge clk);
            if (got || (drop_early && i == 1)) begin
                if (port) bus.req1 = 0; else bus.req0 = 0;
            end
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic run_both(input logic e0, input logic [6:0] a0,
                            input logic e1, input logic [6:0] a1,
                            input int ncyc, input bit hold,
                            output int n0, output int n1, output int t0, output int t1);
        logic s0, s1;
        @(negedge clk);
        bus.req0 = e0; bus.we0 = 0; bus.addr0 = a0;
        bus.req1 = e1; bus.we1 = 0; bus.addr1 = a1;
        n0 = 0; n1 = 0; t0 = 0; t1 = 0;
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge clk); #2;
            s0 = bus.ack0; s1 = bus.ack1;
            if (s0) begin n0++; if (t0 == 0) t0 = i; end
            if (s1) begin n1++; if (t1 == 0) t1 = i; end
            @(negedge clk);
            if (s0 && !hold) bus.req0 = 0;
            if (s1 && !hold) bus.req1 = 0;
        end
        bus.req0 = 0; bus.req1 = 0;
    endtask

    initial begin
        int lat, en_cnt, n0, n1, t0, t1;
        logic rw;
        logic [31:0] rd;

        reset = 1;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_en",    {31'd0, bus.ram_en}, 32'd0);
        chk("rst_rw",    {31'd0, bus.ram_rw}, 32'd1);
        chk("rst_addr",  {25'd0, bus.ram_addr}, 32'd0);
        chk("rst_acks",  {30'd0, bus.ack1, bus.ack0}, 32'd0);
        chk("rst_rdata", bus.rdata0 | bus.rdata1, 32'd0);
        @(negedge clk);
        reset = 0;

        // Single write then read on the data port
        do_access(0, 1, 7'd5, 32'hDEADBEEF, 0, lat, en_cnt, rw, rd);
        chk("t1_wr_lat", lat, 32'd2);
        chk("t1_wr_en",  en_cnt, 32'd1);
        chk("t1_wr_rw",  {31'd0, rw}, 32'd0);
        do_access(0, 0, 7'd5, 32'd0, 0, lat, en_cnt, rw, rd);
        chk("t1_rd_lat", lat, 32'd2);
        chk("t1_rd_en",  en_cnt, 32'd1);
        chk("t1_rd_rw",  {31'd0, rw}, 32'd1);
        chk("t1_rdata",  rd, 32'hDEADBEEF);

        // Tie: port 0 first, port 1 three cycles later
        do_access(0, 1, 7'd3, 32'h33333333, 0, lat, en_cnt, rw, rd);
        do_access(1, 1, 7'd7, 32'h77777777, 0, lat, en_cnt, rw, rd);
        run_both(1, 7'd3, 1, 7'd7, 6, 0, n0, n1, t0, t1);
        chk("t2_ack0_at", t0, 32'd2);
        chk("t2_ack1_at", t1, 32'd5);
        chk("t2_rdata0",  bus.rdata0, 32'h33333333);
        chk("t2_rdata1",  bus.rdata1, 32'h77777777);

        // Both ports held for four access slots
        run_both(1, 7'd3, 1, 7'd7, 12, 1, n0, n1, t0, t1);
`ifdef RAM_ARB_RR_EN
        chk("t3_n0", n0, 32'd2);
        chk("t3_n1", n1, 32'd2);
        chk("t3_first1", t1, 32'd5);
`else
        chk("t3_n0", n0, 32'd4);
        chk("t3_n1", n1, 32'd0);
`endif

        // Reset in the ACCESS cycle of a read
        @(negedge clk);
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 7'd5;
        @(posedge clk); #2;
        chk("t4_pre_en", {31'd0, bus.ram_en}, 32'd1);
        @(negedge clk);
        reset = 1; bus.req0 = 0;
        @(posedge clk); #2;
        chk("t4_en",    {31'd0, bus.ram_en}, 32'd0);
        chk("t4_rw",    {31'd0, bus.ram_rw}, 32'd1);
        chk("t4_ack0",  {31'd0, bus.ack0}, 32'd0);
        chk("t4_rdata", bus.rdata0, 32'd0);
        @(negedge clk);
        reset = 0;
        @(posedge clk); #2;
        chk("t4_noack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
        do_access(0, 0, 7'd5, 32'd0, 0, lat, en_cnt, rw, rd);
        chk("t4_lat",   lat, 32'd2);
        chk("t4_fresh", rd, 32'hDEADBEEF);

        // Address extremes, then a held request yields a second access
        do_access(1, 1, 7'd127, 32'hA5A5A5A5, 0, lat, en_cnt, rw, rd);
        do_access(0, 1, 7'd0,   32'h5A5A5A5A, 0, lat, en_cnt, rw, rd);
        do_access(0, 0, 7'd127, 32'd0, 0, lat, en_cnt, rw, rd);
        chk("t5_rd127", rd, 32'hA5A5A5A5);
        do_access(1, 0, 7'd0, 32'd0, 0, lat, en_cnt, rw, rd);
        chk("t5_rd0", rd, 32'h5A5A5A5A);
        run_both(0, 7'd0, 1, 7'd0, 6, 1, n0, n1, t0, t1);
        chk("t5_hold_n1", n1, 32'd2);
        chk("t5_hold_t1", t1, 32'd2);

        // Request withdrawn during ACCESS still completes
        do_access(1, 0, 7'd127, 32'd0, 1, lat, en_cnt, rw, rd);
        chk("t6_lat",   lat, 32'd2);
        chk("t6_rdata", rd, 32'hA5A5A5A5);

        repeat (3) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
